// File: rtl/miriscv_pkg.sv
// Shared constants and types for the miriscv data-side memory model.
package miriscv_pkg;

  localparam int XLEN        = 32;
  localparam int MEM_LAT_MAX = 4;
  localparam int XBYTES      = XLEN / 8;

  // One response beat as it travels down the delay line.
  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] data;
  } resp_t;

endpackage

// File: rtl/miriscv_resp_pipe.sv
// Response delay line: LATENCY-deep shift register. Stage 0 is the read
// register that captures the memory word on the request edge.
module miriscv_resp_pipe
  import miriscv_pkg::*;
#(
  parameter int LATENCY = 1,
  parameter int WIDTH   = XLEN + 1
) (
  input  logic             clk_i,
  input  logic             arstn_i,
  input  logic [WIDTH-1:0] in_i,
  output logic [WIDTH-1:0] out_o
);

  logic [WIDTH-1:0] stage_q [LATENCY];

  // Shift responses one stage per cycle; reset drops everything in flight.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      for (int i = 0; i < LATENCY; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= in_i;
      for (int i = 1; i < LATENCY; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign out_o = stage_q[LATENCY-1];

endmodule

// File: rtl/miriscv_data_mem_resp.sv
// Data memory with fixed-latency responses, byte-enable writes and a sticky
// out-of-range error flag. Memory contents survive reset.
module miriscv_data_mem_resp
  import miriscv_pkg::*;
#(
  parameter int              DEPTH     = 1024,
  parameter logic [XLEN-1:0] BASE_ADDR = 32'h0000_0000,
  parameter int              LATENCY   = 1
) (
  input  logic              clk_i,
  input  logic              arstn_i,
  input  logic              data_req_i,
  input  logic              data_we_i,
  input  logic [XBYTES-1:0] data_be_i,
  input  logic [XLEN-1:0]   data_addr_i,
  input  logic [XLEN-1:0]   data_wdata_i,
  output logic              data_rvalid_o,
  output logic [XLEN-1:0]   data_rdata_o,
  output logic              err_o
);

  localparam int            IDX_W = $clog2(DEPTH);
  // Byte span held one bit wider so BASE_ADDR + span == 2^32 is representable.
  localparam logic [XLEN:0] SPAN  = (XLEN+1)'(DEPTH * XBYTES);

  logic [XLEN-1:0]  mem [DEPTH];
  logic [XLEN-1:0]  offset;
  logic             in_range;
  logic [IDX_W-1:0] idx;
  logic             wr_en;
  logic [XLEN-1:0]  rd_word;
  logic             err_q;
  resp_t            pipe_in;
  resp_t            pipe_out;

  // The lower-bound test keeps addresses below BASE_ADDR from aliasing via
  // wraparound of the subtraction.
  assign offset   = data_addr_i - BASE_ADDR;
  assign in_range = (data_addr_i >= BASE_ADDR) && ({1'b0, offset} < SPAN);
  assign idx      = offset[IDX_W+1:2];
  assign wr_en    = data_req_i & data_we_i & in_range & arstn_i;

  // Byte-lane writes; no reset so the array maps onto RAM.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int b = 0; b < XBYTES; b++) begin
        if (data_be_i[b]) mem[idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
      end
    end
  end

  // Old word is captured into stage 0 on the same edge as any write: read-first.
  always_comb begin
    rd_word = '0;
    if (data_req_i && !data_we_i && in_range) rd_word = mem[idx];
    pipe_in.valid = data_req_i;
    pipe_in.data  = rd_word;
  end

  miriscv_resp_pipe #(
    .LATENCY (LATENCY),
    .WIDTH   (XLEN + 1)
  ) u_resp_pipe (
    .clk_i   (clk_i),
    .arstn_i (arstn_i),
    .in_i    (pipe_in),
    .out_o   (pipe_out)
  );

  // Sticky error: any out-of-range request sets it until reset.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) err_q <= 1'b0;
    else if (data_req_i && !in_range) err_q <= 1'b1;
  end

  assign data_rvalid_o = pipe_out.valid;
  assign data_rdata_o  = pipe_out.data;
  assign err_o         = err_q;

endmodule

// File: doc/miriscv_data_mem_resp.md
MIRISCV_DATA_MEM_RESP -- requirements
Module: miriscv_data_mem_resp

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, meaning memory size in 32-bit words (power of 2, >=4).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, meaning byte address of word 0 (aligned to DEPTH*4).
REQ-003 SHALL have parameter LATENCY, default 1, meaning cycles from request to response (legal range 1..MEM_LAT_MAX).
REQ-004 SHALL have port clk_i  input  1  single clock, all state updates on rising edge.
REQ-005 SHALL have port arstn_i  input  1  asynchronous active-low reset.
REQ-006 SHALL have port data_req_i  input  1  request valid; one request accepted per cycle, no backpressure.
REQ-007 SHALL have port data_we_i  input  1  1 = write, 0 = read.
REQ-008 SHALL have port data_be_i  input  4  byte enables for writes, bit n selects byte lane n.
REQ-009 SHALL have port data_addr_i  input  32  byte address.
REQ-010 SHALL have port data_wdata_i  input  32  write data, lane-aligned.
REQ-011 SHALL have port data_rvalid_o  output  1  response valid, one pulse per accepted request.
REQ-012 SHALL have port data_rdata_o  output  32  read data, qualified by data_rvalid_o.
REQ-013 SHALL have port err_o  output  1  sticky flag: an out-of-range request has been seen.

Function
REQ-014 Request accepted in every cycle with data_req_i=1; there SHALL be no grant or stall path.
REQ-015 In range: BASE_ADDR <= addr < BASE_ADDR+DEPTH*4; word index = (addr-BASE_ADDR)[log2(DEPTH)+1:2]; addr[1:0] ignored.
REQ-016 In-range write SHALL update only byte lanes with data_be_i[n]=1 at the rising edge of the request cycle; data_be_i=0 leaves the word unchanged.
REQ-017 Read SHALL sample the memory word as it stands before any write in the same edge; a write in cycle N is visible to reads issued in cycle N+1 or later.
REQ-018 Every accepted request SHALL produce data_rvalid_o=1 exactly LATENCY cycles after acceptance, in issue order.
REQ-019 Back-to-back requests SHALL give back-to-back responses; throughput one response per cycle with no bubbles.
REQ-020 data_rdata_o SHALL be the full 32-bit word for reads, 32'h0 for writes, and 32'h0 whenever data_rvalid_o=0.
REQ-021 Out-of-range request SHALL not modify memory, SHALL still respond after LATENCY with rdata 32'h0, and SHALL set err_o from the next cycle.
REQ-022 err_o SHALL stay set until reset.
REQ-023 Response pipeline SHALL be a LATENCY-deep shift register of {valid, rdata}; the internal read register forms stage 1.
REQ-024 Address wrap at top of 32-bit space SHALL be treated as out of range (no modular aliasing).

Reset
REQ-025 arstn_i low SHALL asynchronously clear data_rvalid_o, data_rdata_o, err_o and all pipeline stages.
REQ-026 Responses in flight at reset assertion SHALL be discarded and never emitted.
REQ-027 Memory contents SHALL NOT be reset and are retained across reset.
REQ-028 Requests presented while arstn_i is low SHALL be ignored (no write, no response).

Structure
REQ-029 Constant MEM_LAT_MAX (=4) SHALL live in miriscv_pkg next to XLEN; widths SHALL use XLEN.
REQ-030 The response delay line SHALL be sub-module miriscv_resp_pipe (parameter LATENCY, width XLEN+1).
REQ-031 The storage array SHALL be inferable as single-port synchronous RAM with byte write enables.

Verification
REQ-032 LATENCY=1: write 0x12345678 to 0x10 with be=4'hF, read 0x10 next cycle -> rvalid one cycle after the read, rdata 0x12345678.
REQ-033 Write 0xAABBCCDD with be=4'b0101 over a word holding 0x0 -> subsequent read returns 0x00BB00DD.
REQ-034 LATENCY=3: reads of 0x0, 0x4 and 0x8 in three consecutive cycles -> rvalid high in cycles 3, 4 and 5 with matching data, in order.
REQ-035 DEPTH=1024: read 0x1000 -> rvalid with rdata 0x0, err_o rises the next cycle, memory unchanged.
REQ-036 Same-cycle edge case: write 0x1 to 0x20 then read 0x20 in the following cycle -> reads 0x1; a read issued in the cycle before the write returns the old value.
REQ-037 Reset asserted with 2 responses in flight (LATENCY=3) -> no rvalid pulses after release, err_o=0, previously written data still readable.
